// File: rtl/dw_asymfifo_s1_lvl.sv
// Single-clock FIFO with asymmetric push/pop widths, flip-flop storage and level flags.
// Define DW_ASYMFIFO_S1_LVL_FWFT_EN for a combinational first-word-fall-through data_out.
module dw_asymfifo_s1_lvl #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int DEPTH          = 8,
  parameter int ERR_MODE       = 0,
  parameter int BYTE_ORDER     = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_req_n,
  input  logic                        flush_n,
  input  logic                        pop_req_n,
  input  logic [DATA_IN_WIDTH-1:0]    data_in,
  input  logic [$clog2(DEPTH):0]      ae_level,
  input  logic [$clog2(DEPTH):0]      af_level,
  output logic                        empty,
  output logic                        almost_empty,
  output logic                        half_full,
  output logic                        almost_full,
  output logic                        full,
  output logic                        ram_full,
  output logic                        part_wd,
  output logic                        error,
  output logic [$clog2(DEPTH):0]      word_count,
  output logic [DATA_OUT_WIDTH-1:0]   data_out
);

  localparam int AW  = $clog2(DEPTH);
  localparam int W   = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH : DATA_OUT_WIDTH;
  localparam int KI  = (DATA_IN_WIDTH < DATA_OUT_WIDTH) ? DATA_OUT_WIDTH / DATA_IN_WIDTH : 1;
  localparam int KO  = (DATA_IN_WIDTH > DATA_OUT_WIDTH) ? DATA_IN_WIDTH / DATA_OUT_WIDTH : 1;
  localparam int IIW = (KI > 1) ? $clog2(KI) : 1;
  localparam int OIW = (KO > 1) ? $clog2(KO) : 1;
  localparam logic [AW:0]    DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]    HALF_C  = (AW+1)'((DEPTH + 1) / 2);
  localparam logic [AW-1:0]  PLAST   = AW'(DEPTH - 1);
  localparam logic [IIW-1:0] ILAST   = IIW'(KI - 1);
  localparam logic [OIW-1:0] OLAST   = OIW'(KO - 1);

  logic [W-1:0]   r_mem [DEPTH];
  logic [AW-1:0]  r_wptr, r_rptr;
  logic [AW:0]    r_cnt;
  logic [W-1:0]   r_inbuf;
  logic [IIW-1:0] r_idx;
  logic [OIW-1:0] r_oidx;
  logic           r_err;

  logic w_empty, w_ram_full, w_full, w_part;
  logic w_push, w_pop, w_flush, w_wr, w_rd, w_err_now;
  logic [W-1:0]              w_asm, w_head;
  logic [DATA_OUT_WIDTH-1:0] w_sub;
  logic [AW+1:0]             w_af_sum;

  // With equal or wide-in widths KI = 1, so every push completes a word and part_wd stays 0.
  assign w_empty    = (r_cnt == '0);
  assign w_ram_full = (r_cnt == DEPTH_C);
  assign w_part     = (r_idx != '0);
  assign w_full     = w_ram_full && (r_idx == ILAST);
  assign w_push     = !push_req_n && !w_full;
  assign w_flush    = !flush_n && w_part && !w_ram_full;
  assign w_pop      = !pop_req_n && !w_empty;
  assign w_wr       = (w_push && (r_idx == ILAST)) || w_flush;
  assign w_rd       = w_pop && (r_oidx == OLAST);
  assign w_err_now  = (!push_req_n && w_full) || (!pop_req_n && w_empty) ||
                      (!flush_n && w_part && w_ram_full);
  assign w_head     = r_mem[r_rptr];

  always_comb begin
    w_asm = r_inbuf;
    for (int unsigned i = 0; i < KI; i++) begin
      if (w_push && (r_idx == IIW'(i)))
        w_asm[((BYTE_ORDER == 0) ? (KI - 1 - i) : i) * DATA_IN_WIDTH +: DATA_IN_WIDTH] = data_in;
    end
  end

  always_comb begin
    w_sub = '0;
    for (int unsigned j = 0; j < KO; j++) begin
      if (r_oidx == OIW'(j))
        w_sub = w_head[((BYTE_ORDER == 0) ? (KO - 1 - j) : j) * DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_asm;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_inbuf <= '0;
      r_idx   <= '0;
      r_oidx  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_wr) begin
        r_inbuf <= '0;
        r_idx   <= '0;
        r_wptr  <= (r_wptr == PLAST) ? '0 : r_wptr + AW'(1);
      end else if (w_push) begin
        r_inbuf <= w_asm;
        r_idx   <= r_idx + IIW'(1);
      end
      if (w_pop) begin
        if (w_rd) begin
          r_oidx <= '0;
          r_rptr <= (r_rptr == PLAST) ? '0 : r_rptr + AW'(1);
        end else begin
          r_oidx <= r_oidx + OIW'(1);
        end
      end
      case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      r_err <= (ERR_MODE == 0) ? (r_err | w_err_now) : w_err_now;
    end
  end

`ifdef DW_ASYMFIFO_S1_LVL_FWFT_EN
  assign data_out = w_empty ? '0 : w_sub;
`else
  logic [DATA_OUT_WIDTH-1:0] r_dout;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_dout <= '0;
    else if (w_pop) r_dout <= w_sub;
  end
  assign data_out = r_dout;
`endif

  assign w_af_sum     = {1'b0, r_cnt} + {1'b0, af_level};
  assign empty        = w_empty;
  assign almost_empty = (r_cnt <= ae_level);
  assign half_full    = (r_cnt >= HALF_C);
  assign almost_full  = !rst && (w_af_sum >= {1'b0, DEPTH_C});
  assign full         = w_full;
  assign ram_full     = w_ram_full;
  assign part_wd      = w_part;
  assign error        = r_err;
  assign word_count   = r_cnt;

endmodule

// File: tb/tb_dw_asymfifo_s1_lvl.sv
// Scoreboard bench for dw_asymfifo_s1_lvl: narrow-in (both byte orders), wide-in and equal-width instances.
module tb_dw_asymfifo_s1_lvl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // a/b: 8->16 depth 4, byte order 0/1, shared inputs
  logic ab_push_n, ab_flush_n, ab_pop_n;
  logic [7:0] ab_din;
  logic a_empty, a_ae, a_hf, a_af, a_full, a_rf, a_pw, a_err;
  logic b_empty, b_ae, b_hf, b_af, b_full, b_rf, b_pw, b_err;
  logic [2:0] a_wc, b_wc;
  logic [15:0] a_dout, b_dout;
  // c: 16->8 depth 4
  logic c_push_n, c_flush_n, c_pop_n;
  logic [15:0] c_din;
  logic c_empty, c_ae, c_hf, c_af, c_full, c_rf, c_pw, c_err;
  logic [2:0] c_wc;
  logic [7:0] c_dout;
  // d: 8->8 depth 3
  logic d_push_n, d_flush_n, d_pop_n;
  logic [7:0] d_din;
  logic d_empty, d_ae, d_hf, d_af, d_full, d_rf, d_pw, d_err;
  logic [2:0] d_wc;
  logic [7:0] d_dout;

  logic [15:0] qa[$], qb[$];
  logic [7:0]  qc[$], qd[$];
  logic a_pend = 1'b0, b_pend = 1'b0, c_pend = 1'b0, d_pend = 1'b0;

  dw_asymfifo_s1_lvl #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(16), .DEPTH(4), .ERR_MODE(0), .BYTE_ORDER(0)) u_a (
    .clk(clk), .rst(rst), .push_req_n(ab_push_n), .flush_n(ab_flush_n), .pop_req_n(ab_pop_n),
    .data_in(ab_din), .ae_level(3'd0), .af_level(3'd0),
    .empty(a_empty), .almost_empty(a_ae), .half_full(a_hf), .almost_full(a_af), .full(a_full),
    .ram_full(a_rf), .part_wd(a_pw), .error(a_err), .word_count(a_wc), .data_out(a_dout));

  dw_asymfifo_s1_lvl #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(16), .DEPTH(4), .ERR_MODE(0), .BYTE_ORDER(1)) u_b (
    .clk(clk), .rst(rst), .push_req_n(ab_push_n), .flush_n(ab_flush_n), .pop_req_n(ab_pop_n),
    .data_in(ab_din), .ae_level(3'd0), .af_level(3'd0),
    .empty(b_empty), .almost_empty(b_ae), .half_full(b_hf), .almost_full(b_af), .full(b_full),
    .ram_full(b_rf), .part_wd(b_pw), .error(b_err), .word_count(b_wc), .data_out(b_dout));

  dw_asymfifo_s1_lvl #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(8), .DEPTH(4), .ERR_MODE(0), .BYTE_ORDER(0)) u_c (
    .clk(clk), .rst(rst), .push_req_n(c_push_n), .flush_n(c_flush_n), .pop_req_n(c_pop_n),
    .data_in(c_din), .ae_level(3'd1), .af_level(3'd1),
    .empty(c_empty), .almost_empty(c_ae), .half_full(c_hf), .almost_full(c_af), .full(c_full),
    .ram_full(c_rf), .part_wd(c_pw), .error(c_err), .word_count(c_wc), .data_out(c_dout));

  dw_asymfifo_s1_lvl #(.DATA_IN_WIDTH(8), .DATA_OUT_WIDTH(8), .DEPTH(3), .ERR_MODE(0), .BYTE_ORDER(0)) u_d (
    .clk(clk), .rst(rst), .push_req_n(d_push_n), .flush_n(d_flush_n), .pop_req_n(d_pop_n),
    .data_in(d_din), .ae_level(3'd0), .af_level(3'd0),
    .empty(d_empty), .almost_empty(d_ae), .half_full(d_hf), .almost_full(d_af), .full(d_full),
    .ram_full(d_rf), .part_wd(d_pw), .error(d_err), .word_count(d_wc), .data_out(d_dout));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic unexpected(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: pop accepted with no expected data queued", name);
  endtask

  // Monitor: an accepted pop is seen at the edge; the registered data is compared half a cycle later.
  always @(posedge clk) begin
    a_pend <= !ab_pop_n && !a_empty;
    b_pend <= !ab_pop_n && !b_empty;
    c_pend <= !c_pop_n && !c_empty;
    d_pend <= !d_pop_n && !d_empty;
  end

  always @(negedge clk) begin
    if (a_pend) begin
      if (qa.size() == 0) unexpected("a_data"); else chk("a_data", a_dout, qa.pop_front());
    end
    if (b_pend) begin
      if (qb.size() == 0) unexpected("b_data"); else chk("b_data", b_dout, qb.pop_front());
    end
    if (c_pend) begin
      if (qc.size() == 0) unexpected("c_data"); else chk("c_data", c_dout, qc.pop_front());
    end
    if (d_pend) begin
      if (qd.size() == 0) unexpected("d_data"); else chk("d_data", d_dout, qd.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  logic [15:0] c_words [4] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0708};
  logic        c_exp_ae [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        c_exp_hf [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic        c_exp_af [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic        c_exp_fu [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0]  c_subs [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h08};

  initial begin
    rst = 1'b1;
    ab_push_n = 1'b1; ab_flush_n = 1'b1; ab_pop_n = 1'b1; ab_din = '0;
    c_push_n = 1'b1;  c_flush_n = 1'b1;  c_pop_n = 1'b1;  c_din = '0;
    d_push_n = 1'b1;  d_flush_n = 1'b1;  d_pop_n = 1'b1;  d_din = '0;
    repeat (2) tick();
    chk("rst_empty", a_empty, 1); chk("rst_ae", a_ae, 1);   chk("rst_hf", a_hf, 0);
    chk("rst_af", a_af, 0);       chk("rst_full", a_full, 0); chk("rst_pw", a_pw, 0);
    chk("rst_err", a_err, 0);     chk("rst_wc", a_wc, 0);   chk("rst_dout", a_dout, 0);
    chk("rst_c_empty", c_empty, 1); chk("rst_d_rf", d_rf, 0);
    rst = 1'b0;
    tick();

    // wide-in: pop while empty, then subword order and levels
    c_pop_n = 1'b0; tick(); c_pop_n = 1'b1;
    chk("c_pop_empty_err", c_err, 1); chk("c_pop_empty_wc", c_wc, 0);
    c_push_n = 1'b0; c_din = 16'h1234; tick(); c_push_n = 1'b1;
    chk("c_wc_1", c_wc, 1); chk("c_ae_1", c_ae, 1);
    c_pop_n = 1'b0; qc.push_back(8'h12); tick();
    chk("c_wc_after_1st_pop", c_wc, 1);
    qc.push_back(8'h34); tick(); c_pop_n = 1'b1;
    chk("c_wc_after_2nd_pop", c_wc, 0);
    c_push_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c_din = c_words[i]; tick();
      chk("c_fill_wc", c_wc, 32'(i + 1)); chk("c_fill_ae", c_ae, c_exp_ae[i]);
      chk("c_fill_hf", c_hf, c_exp_hf[i]); chk("c_fill_af", c_af, c_exp_af[i]);
      chk("c_fill_full", c_full, c_exp_fu[i]);
    end
    c_push_n = 1'b1;
    c_pop_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      qc.push_back(c_subs[i]); tick();
    end
    c_pop_n = 1'b1;
    chk("c_drained_wc", c_wc, 0); chk("c_drained_empty", c_empty, 1); chk("c_err_sticky", c_err, 1);

    // narrow-in: assembly in both byte orders
    ab_push_n = 1'b0; ab_din = 8'hAA; tick();
    chk("a_pw_half", a_pw, 1); chk("a_wc_half", a_wc, 0);
    ab_din = 8'hBB; tick(); ab_push_n = 1'b1;
    chk("a_wc_word", a_wc, 1); chk("a_pw_word", a_pw, 0); chk("b_wc_word", b_wc, 1);
    ab_pop_n = 1'b0; qa.push_back(16'hAABB); qb.push_back(16'hBBAA); tick(); ab_pop_n = 1'b1;
    chk("a_wc_popped", a_wc, 0);
    ab_push_n = 1'b0; ab_din = 8'h11; tick(); ab_push_n = 1'b1;
    chk("a_pw_before_flush", a_pw, 1);
    ab_flush_n = 1'b0; tick(); ab_flush_n = 1'b1;
    chk("a_pw_after_flush", a_pw, 0); chk("a_wc_after_flush", a_wc, 1);
    ab_pop_n = 1'b0; qa.push_back(16'h1100); qb.push_back(16'h0011); tick(); ab_pop_n = 1'b1;
    ab_push_n = 1'b0; ab_din = 8'h22; tick();
    ab_din = 8'h33; ab_flush_n = 1'b0; tick(); ab_push_n = 1'b1; ab_flush_n = 1'b1;
    chk("a_push_flush_wc", a_wc, 1); chk("a_push_flush_pw", a_pw, 0);
    ab_pop_n = 1'b0; qa.push_back(16'h2233); qb.push_back(16'h3322); tick(); ab_pop_n = 1'b1;
    chk("a_no_err_yet", a_err, 0);

    // narrow-in full: ram full alone is not full until the buffer is one subword short
    ab_push_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      ab_din = 8'(i); tick();
    end
    chk("a_ram_full", a_rf, 1); chk("a_not_full", a_full, 0); chk("a_hf_full", a_hf, 1);
    ab_din = 8'h09; tick();
    chk("a_full", a_full, 1); chk("a_pw_full", a_pw, 1);
    ab_din = 8'h0A; tick(); ab_push_n = 1'b1;
    chk("a_push_full_err", a_err, 1); chk("a_wc_rejected", a_wc, 4);
    ab_flush_n = 1'b0; tick(); ab_flush_n = 1'b1;
    chk("a_flush_rejected_pw", a_pw, 1); chk("a_flush_rejected_wc", a_wc, 4);
    ab_pop_n = 1'b0;
    qa.push_back(16'h0102); qb.push_back(16'h0201); tick();
    qa.push_back(16'h0304); qb.push_back(16'h0403); tick();
    qa.push_back(16'h0506); qb.push_back(16'h0605); tick();
    qa.push_back(16'h0708); qb.push_back(16'h0807); tick();
    ab_pop_n = 1'b1;
    chk("a_wc_drained", a_wc, 0); chk("a_pw_kept", a_pw, 1);
    ab_flush_n = 1'b0; tick(); ab_flush_n = 1'b1;
    chk("a_wc_late_flush", a_wc, 1);
    ab_pop_n = 1'b0; qa.push_back(16'h0900); qb.push_back(16'h0009); tick(); ab_pop_n = 1'b1;
    chk("a_err_sticky", a_err, 1);

    // equal widths, depth 3: reject push on full even with a pop, pointer wrap
    d_push_n = 1'b0;
    d_din = 8'h10; tick(); d_din = 8'h20; tick(); d_din = 8'h30; tick();
    chk("d_full", d_full, 1); chk("d_wc_3", d_wc, 3); chk("d_no_err", d_err, 0);
    d_din = 8'h40; d_pop_n = 1'b0; qd.push_back(8'h10); tick();
    chk("d_push_full_err", d_err, 1); chk("d_wc_2", d_wc, 2); chk("d_not_full", d_full, 0);
    d_din = 8'h50; qd.push_back(8'h20); tick();
    chk("d_push_pop_wc", d_wc, 2);
    d_push_n = 1'b1;
    qd.push_back(8'h30); tick(); qd.push_back(8'h50); tick();
    d_pop_n = 1'b1;
    chk("d_wc_0", d_wc, 0); chk("d_empty", d_empty, 1); chk("d_err_sticky", d_err, 1);

    // asynchronous reset in the middle of a burst
    ab_push_n = 1'b0; ab_din = 8'hCC; c_push_n = 1'b0; c_din = 16'hBEEF; d_push_n = 1'b0; d_din = 8'h77;
    repeat (3) tick();
    chk("pre_rst_a_pw", a_pw, 1); chk("pre_rst_d_full", d_full, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_a_wc", a_wc, 0);     chk("arst_a_pw", a_pw, 0);    chk("arst_a_err", a_err, 0);
    chk("arst_a_empty", a_empty, 1); chk("arst_a_dout", a_dout, 0);
    chk("arst_c_wc", c_wc, 0);     chk("arst_c_af", c_af, 0);    chk("arst_c_err", c_err, 0);
    chk("arst_d_full", d_full, 0); chk("arst_d_dout", d_dout, 0); chk("arst_d_ae", d_ae, 1);
    ab_push_n = 1'b1; c_push_n = 1'b1; d_push_n = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    d_push_n = 1'b0; d_din = 8'h99; tick(); d_push_n = 1'b1;
    chk("post_rst_d_wc", d_wc, 1);
    d_pop_n = 1'b0; qd.push_back(8'h99); tick(); d_pop_n = 1'b1;
    chk("post_rst_d_empty", d_empty, 1);

    repeat (2) tick();
    chk("qa_drained", qa.size(), 0); chk("qb_drained", qb.size(), 0);
    chk("qc_drained", qc.size(), 0); chk("qd_drained", qd.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
